// File: rtl/axis_sink_chk.sv
// AXI4-Stream slave sink and checker.
// Accepts beats under a selectable backpressure pattern, stores them in a
// capture FIFO for readout, checks payload bytes against an incrementing
// reference sequence, and flags slave-port protocol violations.
module axis_sink_chk #(
  parameter int               DATA_WIDTH = 8,
  parameter int               FIFO_DEPTH = 16,
  parameter logic [15:0]      LFSR_SEED  = 16'hACE1,
  localparam int              KEEP_WIDTH = DATA_WIDTH / 8,
  localparam int              AW         = $clog2(FIFO_DEPTH),
  localparam int              RW         = DATA_WIDTH + KEEP_WIDTH + 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic [1:0]            cfg_mode,
  input  logic [7:0]            cfg_on,
  input  logic [7:0]            cfg_off,
  input  logic                  cfg_chk_en,
  input  logic [7:0]            cfg_seed,
  input  logic                  cfg_restart,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [RW-1:0]         rd_data,
  output logic [AW:0]           fifo_count,
  output logic [31:0]           beat_cnt,
  output logic [31:0]           pkt_cnt,
  output logic [15:0]           err_cnt,
  output logic [DATA_WIDTH-1:0] first_err,
  output logic                  proto_err,
  input  logic                  clr
);

  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  // Saturating add for the error counter.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic            gate_q, gate_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [8:0]      ph_q, ph_d;
  logic [1:0]      mode_q;
  logic [8:0]      eff, per, nxt;

  logic [RW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     cnt_q;
  logic            push, pop;

  logic [7:0]      exp_q, lane_exp;
  logic [15:0]     nerr;

  logic                  stall_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [KEEP_WIDTH-1:0] keep_q;
  logic                  last_q;
  logic                  viol;

  // Ready is registered gate plus occupancy; no path from tvalid.
  assign s_axis_tready = gate_q & (cnt_q != FULL) & ~clr;
  assign push          = s_axis_tvalid & s_axis_tready;
  assign rd_valid      = (cnt_q != '0);
  assign pop           = rd_valid & rd_ready;
  assign rd_data       = mem[rptr_q];
  assign fifo_count    = cnt_q;

  // Next gate value; a mode change restarts the periodic phase at on-phase start.
  always_comb begin
    eff    = (cfg_mode != mode_q) ? 9'd0 : ph_q;
    per    = {1'b0, cfg_on} + {1'b0, cfg_off};
    nxt    = eff + 9'd1;
    ph_d   = 9'd0;
    gate_d = 1'b0;
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    case (cfg_mode)
      2'd0: gate_d = 1'b1;
      2'd1: gate_d = 1'b0;
      2'd2: begin
        gate_d = (eff < {1'b0, cfg_on});
        ph_d   = (nxt >= per) ? 9'd0 : nxt;
      end
      default: gate_d = lfsr_q[0];
    endcase
  end

  // Backpressure generator state; the LFSR free-runs regardless of mode.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      gate_q <= 1'b0;
      lfsr_q <= LFSR_SEED;
      ph_q   <= 9'd0;
      mode_q <= 2'd0;
    end else begin
      gate_q <= gate_d;
      lfsr_q <= lfsr_d;
      ph_q   <= ph_d;
      mode_q <= cfg_mode;
    end
  end

  // Capture FIFO storage; written only on an accepted beat.
  always_ff @(posedge aclk) begin
    if (push) mem[wptr_q] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  // Capture FIFO pointers and occupancy.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Per-beat byte compare; lane_exp ends as the advanced expected byte.
  always_comb begin
    lane_exp = exp_q;
    nerr     = 16'd0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (s_axis_tkeep[i]) begin
        if (s_axis_tdata[8*i +: 8] != lane_exp) nerr = nerr + 16'd1;
        lane_exp = lane_exp + 8'd1;
      end
    end
  end

  // Counters, error capture and expected-byte tracking.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt  <= '0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
      first_err <= '0;
      exp_q     <= cfg_seed;
    end else if (clr) begin
      beat_cnt  <= '0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
      first_err <= '0;
      exp_q     <= cfg_seed;
    end else if (push) begin
      beat_cnt <= beat_cnt + 32'd1;
      if (s_axis_tlast) pkt_cnt <= pkt_cnt + 32'd1;
      if (cfg_chk_en && (nerr != 16'd0)) begin
        err_cnt <= sat_add16(err_cnt, nerr);
        if (err_cnt == 16'd0) first_err <= s_axis_tdata;
      end
      exp_q <= (s_axis_tlast && cfg_restart) ? cfg_seed : lane_exp;
    end
  end

  // A stalled beat must stay valid and unchanged on the next cycle.
  assign viol = stall_q & (~s_axis_tvalid | (s_axis_tdata != data_q) |
                           (s_axis_tkeep != keep_q) | (s_axis_tlast != last_q));

  // Stall tracking and sticky protocol flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stall_q   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      stall_q <= s_axis_tvalid & ~s_axis_tready;
      if (clr)       proto_err <= 1'b0;
      else if (viol) proto_err <= 1'b1;
    end
  end

  // Snapshot of the presented beat for the stability check.
  always_ff @(posedge aclk) begin
    data_q <= s_axis_tdata;
    keep_q <= s_axis_tkeep;
    last_q <= s_axis_tlast;
  end

endmodule

// File: tb/tb_axis_sink_chk.sv
// Testbench for axis_sink_chk: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_axis_sink_chk;

  localparam int DW    = 32;
  localparam int KW    = 4;
  localparam int DEPTH = 4;
  localparam int RW    = DW + KW + 1;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          tvalid, tlast, rd_ready, clr, cfg_chk_en, cfg_restart;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic [1:0]    cfg_mode;
  logic [7:0]    cfg_on, cfg_off, cfg_seed;
  logic          s_axis_tready, rd_valid, proto_err;
  logic [RW-1:0] rd_data;
  logic [2:0]    fifo_count;
  logic [31:0]   beat_cnt, pkt_cnt;
  logic [15:0]   err_cnt;
  logic [DW-1:0] first_err;

  int n_chk = 0;
  int n_err = 0;

  axis_sink_chk #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .LFSR_SEED(16'hACE1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
    .cfg_mode(cfg_mode), .cfg_on(cfg_on), .cfg_off(cfg_off),
    .cfg_chk_en(cfg_chk_en), .cfg_seed(cfg_seed), .cfg_restart(cfg_restart),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .fifo_count(fifo_count), .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt),
    .err_cnt(err_cnt), .first_err(first_err), .proto_err(proto_err),
    .clr(clr)
  );

  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [RW-1:0] mq[$];
  int unsigned   m_beat, m_pkt;
  int            m_err;
  logic [DW-1:0] m_first;
  bit            m_seen, m_proto, m_gate, m_pstall, m_plast;
  logic [7:0]    m_exp;
  logic [15:0]   m_lfsr;
  int            m_n;
  logic [1:0]    m_pmode;
  logic [DW-1:0] m_pdata;
  logic [KW-1:0] m_pkeep;

  task automatic model_reset();
    mq.delete();
    m_beat = 0; m_pkt = 0; m_err = 0; m_first = '0; m_seen = 0; m_proto = 0;
    m_gate = 0; m_pstall = 0; m_exp = cfg_seed; m_lfsr = 16'hACE1;
    m_n = 0; m_pmode = 2'd0;
  endtask

  // Beat whose kept lanes continue the reference sequence from e.
  function automatic logic [DW-1:0] mk(logic [7:0] e, logic [KW-1:0] k);
    logic [DW-1:0] d;
    for (int i = 0; i < KW; i++) begin
      if (k[i]) begin d[8*i +: 8] = e; e = e + 8'd1; end
      else d[8*i +: 8] = 8'($urandom);
    end
    return d;
  endfunction

  // One clock cycle: compare DUT to model, then advance the model.
  task automatic cyc(output bit acc);
    bit rdy, pop, viol, bad;
    logic [7:0] e;
    int p;
    #1;
    rdy = m_gate && (mq.size() < DEPTH) && !clr;
    check("tready", s_axis_tready, rdy);
    check("rd_valid", rd_valid, mq.size() != 0);
    check("fifo_count", fifo_count, mq.size());
    if (mq.size() != 0) check("rd_data", rd_data, mq[0]);
    check("beat_cnt", beat_cnt, m_beat);
    check("pkt_cnt", pkt_cnt, m_pkt);
    check("err_cnt", err_cnt, m_err);
    check("first_err", first_err, m_first);
    check("proto_err", proto_err, m_proto);
    acc  = tvalid && rdy;
    pop  = rd_ready && (mq.size() != 0);
    viol = m_pstall && (!tvalid || tdata !== m_pdata || tkeep !== m_pkeep || tlast !== m_plast);
    @(posedge aclk);
    if (clr) begin
      mq.delete();
      m_beat = 0; m_pkt = 0; m_err = 0; m_first = '0; m_seen = 0; m_proto = 0;
      m_exp = cfg_seed;
    end else begin
      if (viol) m_proto = 1;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({tlast, tkeep, tdata});
        m_beat++;
        if (tlast) m_pkt++;
        e = m_exp; bad = 0;
        for (int i = 0; i < KW; i++) begin
          if (tkeep[i]) begin
            if (cfg_chk_en && tdata[8*i +: 8] != e) begin
              bad = 1;
              if (m_err < 65535) m_err++;
            end
            e = e + 8'd1;
          end
        end
        if (bad && !m_seen) begin m_seen = 1; m_first = tdata; end
        m_exp = (tlast && cfg_restart) ? cfg_seed : e;
      end
    end
    m_pstall = tvalid && !rdy;
    m_pdata = tdata; m_pkeep = tkeep; m_plast = tlast;
    if (cfg_mode != m_pmode) m_n = 0;
    case (cfg_mode)
      2'd0: m_gate = 1;
      2'd1: m_gate = 0;
      2'd2: begin
        p = int'(cfg_on) + int'(cfg_off);
        m_gate = (p != 0) && ((m_n % p) < int'(cfg_on));
        m_n++;
      end
      default: m_gate = m_lfsr[0];
    endcase
    if (cfg_mode != 2'd2) m_n = 0;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    m_pmode = cfg_mode;
    @(negedge aclk);
  endtask

  task automatic send(logic [DW-1:0] d, logic [KW-1:0] k, bit l);
    bit a;
    tvalid = 1; tdata = d; tkeep = k; tlast = l;
    a = 0;
    for (int c = 0; c < 40 && !a; c++) cyc(a);
    if (!a) check("send_timeout", 0, 1);
    tvalid = 0;
  endtask

  task automatic do_clr();
    bit a;
    clr = 1; tvalid = 0;
    cyc(a);
    clr = 0;
  endtask

  initial begin
    bit a, have;
    logic [DW-1:0] d, d3;
    logic [KW-1:0] k;
    bit l;
    int j;

    aresetn = 0; tvalid = 0; tdata = '0; tkeep = '0; tlast = 0;
    rd_ready = 0; clr = 0; cfg_mode = 2'd0; cfg_on = 8'd0; cfg_off = 8'd0;
    cfg_chk_en = 1; cfg_seed = 8'h00; cfg_restart = 0;
    repeat (3) @(negedge aclk);
    #1;
    check("rst_tready", s_axis_tready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_beat", beat_cnt, 0);
    check("rst_err", err_cnt, 0);
    check("rst_first", first_err, 0);
    check("rst_proto", proto_err, 0);
    @(negedge aclk);
    aresetn = 1;
    model_reset();
    cyc(a);

    // T1: four in-order beats, one packet, then drain
    for (int b = 0; b < 4; b++) send(32'h03020100 + 32'(b) * 32'h04040404, 4'hF, b == 3);
    #1;
    check("t1_beats", beat_cnt, 4);
    check("t1_pkts", pkt_cnt, 1);
    check("t1_errs", err_cnt, 0);
    check("t1_head", rd_data, {1'b0, 4'hF, 32'h03020100});
    rd_ready = 1;
    repeat (5) cyc(a);
    check("t1_empty", rd_valid, 0);

    // T2: periodic 2 on / 3 off, tvalid held high for 25 cycles
    cfg_mode = 2'd2; cfg_on = 8'd2; cfg_off = 8'd3;
    do_clr();
    tvalid = 1; tkeep = 4'hF; tlast = 0; tdata = mk(m_exp, 4'hF);
    for (int c = 0; c < 25; c++) begin
      cyc(a);
      if (a) tdata = mk(m_exp, 4'hF);
    end
    tvalid = 0;
    #1 check("t2_beats", beat_cnt, 10);

    // T3: fill, stall while full, one pop frees a slot next cycle
    cfg_mode = 2'd0; rd_ready = 0;
    do_clr();
    for (int b = 0; b < 4; b++) send(mk(m_exp, 4'hF), 4'hF, 0);
    tvalid = 1; tdata = mk(m_exp, 4'hF); tkeep = 4'hF; tlast = 0;
    repeat (3) cyc(a);
    #1;
    check("t3_full", fifo_count, 4);
    check("t3_stall", s_axis_tready, 0);
    rd_ready = 1;
    cyc(a);
    rd_ready = 0;
    #1 check("t3_ready_back", s_axis_tready, 1);
    cyc(a);
    tvalid = 0;
    #1;
    check("t3_beats", beat_cnt, 5);
    check("t3_count", fifo_count, 4);

    // T4: corrupted bytes, first_err capture, partial-keep advance
    rd_ready = 1; cfg_seed = 8'h00;
    do_clr();
    send(mk(m_exp, 4'hF), 4'hF, 0);
    send(mk(m_exp, 4'hF), 4'hF, 0);
    d3 = mk(m_exp, 4'hF); d3[23:16] = 8'hFF;
    send(d3, 4'hF, 0);
    #1;
    check("t4_err1", err_cnt, 1);
    check("t4_first", first_err, d3);
    d = mk(m_exp, 4'hF); d[7:0] = ~d[7:0];
    send(d, 4'hF, 0);
    #1;
    check("t4_err2", err_cnt, 2);
    check("t4_first_kept", first_err, d3);
    send(mk(m_exp, 4'b0011), 4'b0011, 0);
    send(32'h15141312, 4'hF, 1);
    #1 check("t4_aligned", err_cnt, 2);

    // T5: stalled beat changes data -> sticky protocol error until clr
    cfg_mode = 2'd1;
    do_clr();
    cyc(a);
    tvalid = 1; tdata = 32'hAAAA5555; tkeep = 4'hF; tlast = 0;
    cyc(a);
    #1 check("t5_no_err_yet", proto_err, 0);
    tdata = 32'h12345678;
    cyc(a);
    #1 check("t5_proto_set", proto_err, 1);
    tvalid = 0;
    repeat (3) cyc(a);
    #1 check("t5_sticky", proto_err, 1);
    do_clr();
    #1 check("t5_cleared", proto_err, 0);

    // T6: reset with three buffered beats, then LFSR ready sequence
    cfg_mode = 2'd0; rd_ready = 0;
    do_clr();
    cyc(a);
    for (int b = 0; b < 3; b++) send(mk(m_exp, 4'hF), 4'hF, 0);
    aresetn = 0; cfg_mode = 2'd3;
    #1;
    check("t6_tready", s_axis_tready, 0);
    check("t6_rd_valid", rd_valid, 0);
    check("t6_count", fifo_count, 0);
    check("t6_beats", beat_cnt, 0);
    check("t6_pkts", pkt_cnt, 0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1;
    model_reset();
    rd_ready = 1;
    repeat (40) cyc(a);

    // Randomized traffic across all modes
    have = 0;
    for (int cy = 0; cy < 1500; cy++) begin
      if (cy % 100 == 0) cfg_mode = 2'd0;
      else if (cy % 100 == 1) begin
        cfg_mode    = 2'($urandom_range(3, 0));
        cfg_on      = 8'($urandom_range(5, 0));
        cfg_off     = 8'($urandom_range(5, 0));
        cfg_chk_en  = ($urandom_range(3, 0) != 0);
        cfg_restart = $urandom_range(1, 0) != 0;
        cfg_seed    = 8'($urandom);
      end
      rd_ready = ($urandom_range(2, 0) != 0);
      clr      = ($urandom_range(149, 0) == 0);
      if (!have) begin
        if ($urandom_range(3, 0) != 0) begin
          have = 1;
          k = ($urandom_range(7, 0) == 0) ? 4'h0 : 4'($urandom);
          l = ($urandom_range(3, 0) == 0);
          d = mk(m_exp, k);
          if ($urandom_range(9, 0) == 0) begin
            j = $urandom_range(KW-1, 0);
            d[8*j +: 8] = ~d[8*j +: 8];
          end
          tvalid = 1; tdata = d; tkeep = k; tlast = l;
        end else tvalid = 0;
      end else if ($urandom_range(59, 0) == 0) begin
        if ($urandom_range(1, 0) != 0) begin tvalid = 0; have = 0; end
        else tdata = tdata ^ 32'h1;
      end
      cyc(a);
      if (a) have = 0;
    end
    clr = 0; tvalid = 0;
    cyc(a);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/axis_sink_chk.md
Name: axis_sink_chk

Overview:
Parametrised AXI4-Stream slave sink and checker for testbenches and loopback tests.
- Accepts beats under a configurable backpressure pattern and buffers them in a capture FIFO for pop-side readout.
- Checks payload bytes against an incrementing reference sequence.
- Counts beats, packets and errors, and flags AXI-Stream protocol violations on the slave port.

Parameters:
DATA_WIDTH, 8, tdata width in bits; multiple of 8; KEEP_WIDTH = DATA_WIDTH/8.
FIFO_DEPTH, 16, capture FIFO entries; power of two, at least 2.
LFSR_SEED, 16'hACE1, reset value of the random-ready LFSR; must be non-zero.

Ports:
aclk  in  1  clock; all logic on the rising edge.
aresetn  in  1  asynchronous active-low reset.
s_axis_tvalid  in  1  slave valid.
s_axis_tready  out  1  slave ready.
s_axis_tdata  in  DATA_WIDTH  slave data.
s_axis_tkeep  in  KEEP_WIDTH  byte qualifiers; lane i is kept when bit i=1.
s_axis_tlast  in  1  end of packet.
cfg_mode  in  2  backpressure mode: 0 always, 1 never, 2 periodic, 3 random.
cfg_on  in  8  periodic mode: ready-phase length in cycles.
cfg_off  in  8  periodic mode: stall-phase length in cycles.
cfg_chk_en  in  1  enable the data checker.
cfg_seed  in  8  first expected byte value.
cfg_restart  in  1  reload the expected byte to cfg_seed after each tlast beat.
rd_valid  out  1  capture FIFO not empty.
rd_ready  in  1  pop request.
rd_data  out  DATA_WIDTH+KEEP_WIDTH+1  FIFO head as {tlast, tkeep, tdata}.
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
beat_cnt  out  32  accepted beats; wraps.
pkt_cnt  out  32  accepted tlast beats; wraps.
err_cnt  out  16  mismatched bytes; saturates at 16'hFFFF.
first_err  out  DATA_WIDTH  tdata of the first mismatching beat.
proto_err  out  1  sticky protocol-violation flag.
clr  in  1  synchronous clear of counters, error state and FIFO contents.

Behaviour:
- Reset (aresetn=0, asynchronous):
  - s_axis_tready=0, rd_valid=0, fifo_count=0, all counters 0, first_err=0, proto_err=0.
  - Gate register = 0; LFSR = LFSR_SEED; phase counter = 0; expected byte = cfg_seed.
- Handshake:
  - A beat is accepted at a rising edge when tvalid & tready.
  - s_axis_tready = gate_q & (fifo_count != FIFO_DEPTH). This is combinational from registers only, with no path from tvalid.
- Gate register, updated every cycle from cfg_mode:
  - Mode 0: gate = 1.
  - Mode 1: gate = 0.
  - Mode 2: gate = 1 for cfg_on cycles, then 0 for cfg_off cycles, repeating.
    - cfg_on=0 gives gate permanently 0.
    - cfg_off=0 gives gate permanently 1.
  - Mode 3: 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing one step per cycle; gate = LFSR bit 0.
  - A change of cfg_mode restarts the mode 2 phase at the start of the on-phase. The LFSR is not reseeded.
- Capture FIFO:
  - The accepted beat is written at the accept edge; rd_valid goes high on the following cycle (1-cycle latency when empty). No bypass path.
  - Pop occurs on rd_valid & rd_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - When full, tready=0 even if a pop is in progress; the freed entry is offered from the next cycle.
  - Pop when empty is ignored.
- Checker, when cfg_chk_en=1, on each accepted beat:
  - For kept lane i, expected byte = exp + (number of kept lanes below i), mod 256.
  - Every mismatching kept byte increments err_cnt (several per beat allowed; saturating).
  - first_err is captured on the first mismatching beat only.
  - exp advances by popcount(tkeep), mod 256.
  - On a tlast beat with cfg_restart=1, exp reloads cfg_seed instead of advancing.
  - A beat with tkeep=0 is counted as a beat but does not change exp.
- Checker disabled (cfg_chk_en=0): exp still advances, so re-enabling stays aligned with the stream.
- Counters: beat_cnt increments on every accepted beat; pkt_cnt increments on every accepted beat with tlast=1.
- Protocol check: proto_err is set when, in the cycle after tvalid=1 and tready=0, either of these holds:
  - tvalid drops to 0, or
  - tdata, tkeep or tlast differ from their previous values.
- clr (synchronous, highest priority after reset):
  - Empties the FIFO and zeroes beat_cnt, pkt_cnt, err_cnt, first_err and proto_err.
  - Reloads exp to cfg_seed.
  - A beat presented in the clr cycle is not accepted (tready is forced to 0).
- Reset mid-packet: all FIFO contents and state are lost; no partial beat survives.

Test Plan:
1. DATA_WIDTH=32, mode 0, cfg_seed=8'h00, 4 beats tdata 32'h03020100..32'h0F0E0D0C, tkeep=4'hF, tlast on beat 4 -> beat_cnt=4, pkt_cnt=1, err_cnt=0, rd_valid high 1 cycle after the first accept, FIFO pops in order.
2. Mode 2, cfg_on=2, cfg_off=3, tvalid held high -> tready pattern 1,1,0,0,0 repeating; 10 beats accepted in 25 cycles.
3. FIFO_DEPTH=4, rd_ready=0, 6 beats offered -> 4 accepted, tready=0 with fifo_count=4; one pop -> tready returns the next cycle, 5th beat accepted.
4. Byte 2 of beat 3 corrupted to 8'hFF -> err_cnt=1, first_err=corrupted tdata; a second error leaves first_err unchanged; tkeep=4'b0011 beat advances exp by 2.
5. Protocol: tvalid=1 with tready=0, tdata changed next cycle -> proto_err=1 and stays set until clr or reset.
6. aresetn asserted mid-packet with 3 beats buffered -> tready, rd_valid and counters 0 immediately; mode 3 after release reproduces the LFSR_SEED ready sequence.
